// File: rtl/arbiter_out_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_out_buffer_pkg
// Brief    : Shared types and helpers for the arbiter output stage.
// Revision : 1.0 - initial release
// ============================================================================
package arbiter_out_buffer_pkg;

  // Occupancy of the two-entry skid buffer
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_e;

  // Width of the shift counter: enough to hold SHIFT_PERIOD, never below 1
  function automatic int unsigned shift_cnt_width(input int unsigned period);
    int unsigned w;
    w = $clog2(period + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arbiter_out_buffer_shift_gen.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_shift_gen
// Brief    : Counts accepted pushes and emits a one-cycle registered shift
//            pulse after every SHIFT_PERIOD of them. SHIFT_PERIOD=0 ties
//            shift low.
// Revision : 1.0 - initial release
// ============================================================================
module arbiter_shift_gen
  import arbiter_out_buffer_pkg::*;
#(
  parameter int unsigned SHIFT_PERIOD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic push,
  output logic shift
);

  localparam int unsigned SCW = shift_cnt_width(SHIFT_PERIOD);

  generate
    if (SHIFT_PERIOD == 0) begin : g_disabled
      logic w_unused;
      assign w_unused = &{1'b0, clk, rst, flush, push};
      assign shift    = 1'b0;
    end else begin : g_enabled
      localparam logic [SCW-1:0] C_LAST = SCW'(SHIFT_PERIOD - 1);

      logic [SCW-1:0] scnt_q, scnt_d;
      logic           shift_q, shift_d;

      // Next-state: wrap the counter and raise the pulse on the last push
      always_comb begin
        scnt_d  = scnt_q;
        shift_d = 1'b0;
        if (flush) begin
          scnt_d  = '0;
        end else if (push) begin
          if (scnt_q == C_LAST) begin
            scnt_d  = '0;
            shift_d = 1'b1;
          end else begin
            scnt_d  = scnt_q + 1'b1;
          end
        end
      end

      // Counter and pulse registers
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          scnt_q  <= '0;
          shift_q <= 1'b0;
        end else begin
          scnt_q  <= scnt_d;
          shift_q <= shift_d;
        end
      end

      assign shift = shift_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/arbiter_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : arbiter_out_buffer
// Brief    : Two-entry skid buffer behind the fixed/shiftable arbiter. Breaks
//            the out_ready->in_ready combinational path and generates the
//            arbiter's fairness shift pulse.
// Revision : 1.0 - initial release
// ============================================================================
module arbiter_out_buffer
  import arbiter_out_buffer_pkg::*;
#(
  parameter int unsigned DWIDTH       = 16,
  parameter int unsigned SHIFT_PERIOD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              shift,
  input  logic              flush,
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  input  logic              out_ready
);

  occ_e              cnt_q, cnt_d;
  logic [DWIDTH-1:0] head_q, head_d;
  logic [DWIDTH-1:0] skid_q, skid_d;
  logic              w_push, w_pop;

  // Handshake flags decode from registered occupancy only
  assign in_ready  = (cnt_q != OCC_FULL);
  assign out_valid = (cnt_q != OCC_EMPTY);
  assign out_data  = head_q;
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  // Occupancy transitions; head always holds the oldest entry
  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    skid_d = skid_q;
    case (cnt_q)
      OCC_EMPTY: begin
        if (w_push) begin
          head_d = in_data;
          cnt_d  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (w_push && w_pop) begin
          head_d = in_data;
        end else if (w_push) begin
          skid_d = in_data;
          cnt_d  = OCC_FULL;
        end else if (w_pop) begin
          cnt_d  = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (w_pop) begin
          head_d = skid_q;
          cnt_d  = OCC_ONE;
        end
      end
      default: cnt_d = OCC_EMPTY;
    endcase
    // Flush discards everything, including a beat offered this cycle
    if (flush) begin
      cnt_d = OCC_EMPTY;
    end
  end

  // Buffer state registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= OCC_EMPTY;
      head_q <= '0;
      skid_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      skid_q <= skid_d;
    end
  end

  arbiter_shift_gen #(
    .SHIFT_PERIOD (SHIFT_PERIOD)
  ) u_shift_gen (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (w_push),
    .shift (shift)
  );

endmodule
`default_nettype wire

// File: tb/tb_arbiter_out_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbiter_out_buffer
// Brief    : Scoreboard bench for arbiter_out_buffer (SHIFT_PERIOD 4 and 0).
// Revision : 1.0 - initial release
// ============================================================================
module tb_arbiter_out_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready, shift, out_valid;
  logic [15:0] out_data;
  logic        in_ready0, shift0, out_valid0;
  logic [15:0] out_data0;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] expq[$];
  logic [15:0] mon_exp;

  always #5 clk = ~clk;

  arbiter_out_buffer #(.DWIDTH(16), .SHIFT_PERIOD(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .shift(shift), .flush(flush),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready)
  );

  arbiter_out_buffer #(.DWIDTH(16), .SHIFT_PERIOD(0)) dut_p0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .shift(shift0), .flush(flush),
    .out_valid(out_valid0), .out_data(out_data0), .out_ready(out_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a beat is consumed at the next edge when valid & ready & !flush
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      check("p0_shift", {31'd0, shift0}, 32'd0);
      if (out_valid && out_ready && !flush) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_beat: got 0x%0h, expected no beat", out_data);
        end else begin
          mon_exp = expq.pop_front();
          check("out_data", {16'd0, out_data}, {16'd0, mon_exp});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with in_valid asserted
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    repeat (3) tick();
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_shift",     {31'd0, shift},     32'd0);
    check("rst_out_data",  {16'd0, out_data},  32'd0);

    // First push on the first edge out of reset
    rst     = 1'b1;
    in_data = 16'hA5A5;
    expq.push_back(16'hA5A5);
    tick();
    check("first_valid", {31'd0, out_valid}, 32'd1);
    check("first_data",  {16'd0, out_data},  32'h0000_A5A5);
    in_valid = 1'b0;
    tick();

    // Streaming, one beat per cycle
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      expq.push_back(16'(i));
      tick();
      check("stream_valid", {31'd0, out_valid}, 32'd1);
      check("stream_ready", {31'd0, in_ready},  32'd1);
    end
    in_valid = 1'b0;
    tick();

    // Backpressure
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h0011;
    expq.push_back(16'h0011);
    tick();
    check("bp_ready_after1", {31'd0, in_ready}, 32'd1);
    in_data = 16'h0022;
    expq.push_back(16'h0022);
    tick();
    check("bp_ready_after2", {31'd0, in_ready}, 32'd0);
    check("bp_head",         {16'd0, out_data}, 32'h0000_0011);
    in_data = 16'h0033;
    tick();
    check("bp_ready_stall", {31'd0, in_ready}, 32'd0);
    tick();
    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
    check("bp_hold_data",  {16'd0, out_data},  32'h0000_0011);
    out_ready = 1'b1;
    tick();
    check("bp_ready_pop1", {31'd0, in_ready}, 32'd1);
    check("bp_head_pop1",  {16'd0, out_data}, 32'h0000_0022);
    expq.push_back(16'h0033);
    tick();
    check("bp_head_33", {16'd0, out_data}, 32'h0000_0033);
    in_valid = 1'b0;
    tick();
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // Shift pulses with SHIFT_PERIOD=4, counter cleared first
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_empty", {31'd0, out_valid}, 32'd0);
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h0100 + 16'(i);
      expq.push_back(16'h0100 + 16'(i));
      tick();
      check("shift_seq", {31'd0, shift}, {31'd0, (i == 4 || i == 8)});
    end
    in_valid = 1'b0;
    tick();
    check("shift_tail", {31'd0, shift}, 32'd0);

    // Flush with buffer full and counter at 3, simultaneous push
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h00B0;
    expq.push_back(16'h00B0);
    tick();
    in_data = 16'h00B1;
    expq.push_back(16'h00B1);
    tick();
    out_ready = 1'b0;
    in_data   = 16'h00B2;
    expq.push_back(16'h00B2);
    tick();
    check("fl_pre_ready", {31'd0, in_ready}, 32'd0);
    flush     = 1'b1;
    out_ready = 1'b1;
    in_data   = 16'hDEAD;
    tick();
    expq.delete();
    flush    = 1'b0;
    in_valid = 1'b0;
    check("fl_out_valid", {31'd0, out_valid}, 32'd0);
    check("fl_in_ready",  {31'd0, in_ready},  32'd1);
    check("fl_shift",     {31'd0, shift},     32'd0);
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1;
      in_data  = 16'h00C0 + 16'(i);
      expq.push_back(16'h00C0 + 16'(i));
      tick();
      check("fl_shift_seq", {31'd0, shift}, {31'd0, (i == 4)});
    end
    in_valid = 1'b0;
    tick();
    check("fl_shift_tail", {31'd0, shift}, 32'd0);

    repeat (3) tick();
    check("queue_empty", expq.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
